datamem_prog: RTL and testbench

DATAMEM_PROG -- requirements
Module: datamem_prog

---
 rtl/datamem_prog.sv | 183 ++++++++++++++++++
 tb/tb_datamem_prog.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datamem_prog.sv
// Data memory shared by a CPU load/store port and a word-wide programmer port.
// Define DATAMEM_SUBWORD_EN to get byte/half accesses and misalign detection; otherwise every access is a full word.
module datamem_prog #(
    parameter int ADDR_BITS = 14
) (
    input  logic                 clock,
    input  logic                 Reset_n,
    input  logic                 Mem_read,
    input  logic                 Memory_write,
    input  logic [1:0]           Mem_size,
    input  logic                 Mem_unsigned,
    input  logic [31:0]          Address,
    input  logic [31:0]          Write_data,
    output logic [31:0]          Read_data,
    output logic                 Read_valid,
    output logic                 Misalign,
    output logic                 Mem_ready,
    input  logic                 Upg_rst_i,
    input  logic                 Upg_wen_i,
    input  logic [ADDR_BITS-1:0] Upg_adr_i,
    input  logic [31:0]          Upg_dat_i,
    input  logic                 Upg_done_i,
    output logic                 Prog_mode
);

    // state   | meaning
    // RUN     | CPU owns the memory
    // PROG    | programmer owns the memory, CPU requests ignored
    // HANDOFF | single idle cycle returning ownership to the CPU
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PROG    = 2'd1,
        HANDOFF = 2'd2
    } state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clock) begin
        if (!Reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Mem_ready = 1'b0;
        Prog_mode = 1'b0;
        case (state)
            RUN: begin
                Mem_ready = 1'b1;
                if (!Upg_rst_i && !Upg_done_i) state_nxt = PROG;
            end
            PROG: begin
                Prog_mode = 1'b1;
                if (Upg_rst_i || Upg_done_i) state_nxt = HANDOFF;
            end
            HANDOFF: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    logic [ADDR_BITS-1:0] word_idx;
    logic                 misaligned;
    logic [3:0]           lane_en;
    logic [31:0]          lane_data;

    // Upper address bits alias onto the same words.
    assign word_idx = Address[ADDR_BITS+1:2];

`ifdef DATAMEM_SUBWORD_EN
    always_comb begin
        misaligned = 1'b0;
        lane_en    = 4'b1111;
        lane_data  = Write_data;
        case (Mem_size)
            2'b00: begin
                lane_en   = 4'b0001 << Address[1:0];
                lane_data = {4{Write_data[7:0]}};
            end
            2'b01: begin
                misaligned = Address[0];
                lane_en    = Address[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{Write_data[15:0]}};
            end
            default: misaligned = |Address[1:0];
        endcase
    end

    wire unused_addr = &{1'b0, Address[31:ADDR_BITS+2]};
`else
    assign misaligned = 1'b0;
    assign lane_en    = 4'b1111;
    assign lane_data  = Write_data;

    wire unused_cfg = &{1'b0, Mem_size, Mem_unsigned, Address[1:0], Address[31:ADDR_BITS+2]};
`endif

    logic access;
    logic store_go;
    logic load_go;
    logic mis_go;
    logic prog_wr;

    // Reset gates acceptance so a request coinciding with reset leaves no trace.
    assign access   = Reset_n && (state == RUN) && (Mem_read || Memory_write);
    assign store_go = access && Memory_write && !misaligned;
    assign load_go  = access && !Memory_write && !misaligned;
    assign mis_go   = access && misaligned;
    assign prog_wr  = Reset_n && (state == PROG) && Upg_wen_i;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;

    // No reset on the array: contents survive Reset_n. The read samples the old word (read-first).
    always_ff @(posedge clock) begin
        rd_word <= mem[word_idx];
        if (prog_wr) begin
            mem[Upg_adr_i] <= Upg_dat_i;
        end else if (store_go) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    logic [31:0] load_val;

`ifdef DATAMEM_SUBWORD_EN
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_ff @(posedge clock) begin
        if (load_go) begin
            lane_q <= Address[1:0];
            size_q <= Mem_size;
            uns_q  <= Mem_unsigned;
        end
    end

    always_comb begin
        load_val = rd_word;
        byte_sel = rd_word[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = rd_word;
        endcase
    end
`else
    assign load_val = rd_word;
`endif

    logic        valid_q;
    logic        mis_q;
    logic [31:0] rd_hold;

    always_ff @(posedge clock) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            rd_hold <= '0;
        end else begin
            valid_q <= load_go;
            mis_q   <= mis_go;
            if (valid_q) rd_hold <= load_val;
            if (mis_go)  rd_hold <= '0;
        end
    end

    assign Read_valid = valid_q;
    assign Misalign   = mis_q;
    assign Read_data  = valid_q ? load_val : rd_hold;

endmodule

// File: tb/tb_datamem_prog.sv
// Bench for datamem_prog: byte-level memory model checked every cycle plus directed literal expectations.
// Follows DATAMEM_SUBWORD_EN the same way the design does.
module tb_datamem_prog;

    localparam int AB    = 14;
    localparam int DEPTH = 1 << AB;
`ifdef DATAMEM_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic          clock;
    logic          Reset_n;
    logic          Mem_read;
    logic          Memory_write;
    logic [1:0]    Mem_size;
    logic          Mem_unsigned;
    logic [31:0]   Address;
    logic [31:0]   Write_data;
    logic [31:0]   Read_data;
    logic          Read_valid;
    logic          Misalign;
    logic          Mem_ready;
    logic          Upg_rst_i;
    logic          Upg_wen_i;
    logic [AB-1:0] Upg_adr_i;
    logic [31:0]   Upg_dat_i;
    logic          Upg_done_i;
    logic          Prog_mode;

    datamem_prog #(.ADDR_BITS(AB)) dut (
        .clock        (clock),
        .Reset_n      (Reset_n),
        .Mem_read     (Mem_read),
        .Memory_write (Memory_write),
        .Mem_size     (Mem_size),
        .Mem_unsigned (Mem_unsigned),
        .Address      (Address),
        .Write_data   (Write_data),
        .Read_data    (Read_data),
        .Read_valid   (Read_valid),
        .Misalign     (Misalign),
        .Mem_ready    (Mem_ready),
        .Upg_rst_i    (Upg_rst_i),
        .Upg_wen_i    (Upg_wen_i),
        .Upg_adr_i    (Upg_adr_i),
        .Upg_dat_i    (Upg_dat_i),
        .Upg_done_i   (Upg_done_i),
        .Prog_mode    (Prog_mode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: byte-addressed memory plus an owner flag (0 CPU, 1 programmer, 2 hand-back).
    logic [7:0]  mbytes [4*DEPTH];
    int          owner  = 0;
    bit          m_live = 1'b0;
    bit          e_valid;
    bit          e_mis;
    logic [31:0] e_data;

    task automatic model_step();
        int          n;
        int          lo;
        int          base;
        logic [31:0] v;
        if (Reset_n !== 1'b1) begin
            owner   = 0;
            e_valid = 1'b0;
            e_mis   = 1'b0;
            e_data  = '0;
            m_live  = 1'b1;
            return;
        end
        e_valid = 1'b0;
        e_mis   = 1'b0;
        case (owner)
            0: begin
                if (Mem_read || Memory_write) begin
                    n    = SUBWORD ? ((Mem_size == 2'b00) ? 1 : (Mem_size == 2'b01) ? 2 : 4) : 4;
                    lo   = SUBWORD ? int'(Address[1:0]) : 0;
                    base = int'(Address[AB+1:2]) * 4;
                    if ((lo % n) != 0) begin
                        e_mis  = 1'b1;
                        e_data = '0;
                    end else if (Memory_write) begin
                        for (int b = 0; b < n; b++) mbytes[base+lo+b] = Write_data[8*b +: 8];
                    end else begin
                        v = '0;
                        for (int b = 0; b < n; b++) v = v | (32'(mbytes[base+lo+b]) << (8*b));
                        if (SUBWORD && !Mem_unsigned && n < 4 && v[8*n-1])
                            v = v | ~((32'h1 << (8*n)) - 32'h1);
                        e_valid = 1'b1;
                        e_data  = v;
                    end
                end
                if (!Upg_rst_i && !Upg_done_i) owner = 1;
            end
            1: begin
                if (Upg_wen_i)
                    for (int b = 0; b < 4; b++) mbytes[int'(Upg_adr_i)*4+b] = Upg_dat_i[8*b +: 8];
                if (Upg_rst_i || Upg_done_i) owner = 2;
            end
            default: owner = 0;
        endcase
    endtask

    always @(posedge clock) begin
        model_step();
        #1;
        if (m_live) begin
            check("cyc_read_valid", Read_valid, e_valid);
            check("cyc_read_data",  Read_data,  e_data);
            check("cyc_misalign",   Misalign,   e_mis);
            check("cyc_mem_ready",  Mem_ready,  owner == 0);
            check("cyc_prog_mode",  Prog_mode,  owner == 1);
        end
    end

    task automatic cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        Memory_write = 1'b1;
        Address      = a;
        Write_data   = d;
        Mem_size     = sz;
        cycle();
        Memory_write = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        Mem_read     = 1'b1;
        Address      = a;
        Mem_size     = sz;
        Mem_unsigned = uns;
        cycle();
        Mem_read = 1'b0;
    endtask

    initial begin
        Reset_n      = 1'b0;
        Mem_read     = 1'b1;
        Memory_write = 1'b0;
        Mem_size     = 2'b10;
        Mem_unsigned = 1'b0;
        Address      = 32'h0;
        Write_data   = 32'h0;
        Upg_rst_i    = 1'b1;
        Upg_wen_i    = 1'b0;
        Upg_adr_i    = '0;
        Upg_dat_i    = 32'h0;
        Upg_done_i   = 1'b0;
        repeat (2) cycle();
        check("reset_valid", Read_valid, 1'b0);
        check("reset_data",  Read_data,  32'h0);
        check("reset_ready", Mem_ready,  1'b1);
        check("reset_prog",  Prog_mode,  1'b0);
        Mem_read = 1'b0;
        Reset_n  = 1'b1;
        cycle();
        check("reset_no_late_valid", Read_valid, 1'b0);

        // Programmer write while the CPU owns memory must be ignored.
        store(32'h24, 32'h1234_5678, 2'b10);
        Upg_wen_i = 1'b1; Upg_adr_i = 14'd9; Upg_dat_i = 32'hCAFE_F00D;
        cycle();
        Upg_wen_i = 1'b0;
        load(32'h24, 2'b10, 1'b0);
        check("run_upg_ignored_valid", Read_valid, 1'b1);
        check("run_upg_ignored_data",  Read_data,  32'h1234_5678);

        // Programming session.
        Upg_rst_i = 1'b0; Upg_done_i = 1'b0;
        cycle();
        check("prog_mode", Prog_mode, 1'b1);
        check("prog_ready", Mem_ready, 1'b0);
        Upg_wen_i = 1'b1; Upg_adr_i = 14'd5; Upg_dat_i = 32'hDEAD_BEEF;
        Mem_read = 1'b1; Address = 32'h24; Mem_size = 2'b10;
        cycle();
        Upg_wen_i = 1'b0; Mem_read = 1'b0;
        check("prog_load_ignored", Read_valid, 1'b0);
        Upg_done_i = 1'b1;
        cycle();
        check("handoff_prog",  Prog_mode, 1'b0);
        check("handoff_ready", Mem_ready, 1'b0);
        Upg_rst_i = 1'b1; Upg_done_i = 1'b0;
        cycle();
        check("back_to_run", Mem_ready, 1'b1);
        load(32'h14, 2'b10, 1'b0);
        check("prog_word_valid", Read_valid, 1'b1);
        check("prog_word_data",  Read_data,  32'hDEAD_BEEF);

        // Sub-word extension.
        store(32'h20, 32'h80FF_7F01, 2'b10);
        load(32'h23, 2'b00, 1'b0);
        check("byte_signed",   Read_data, SUBWORD ? 32'hFFFF_FF80 : 32'h80FF_7F01);
        load(32'h22, 2'b00, 1'b1);
        check("byte_unsigned", Read_data, SUBWORD ? 32'h0000_00FF : 32'h80FF_7F01);
        load(32'h20, 2'b01, 1'b0);
        check("half_low",      Read_data, SUBWORD ? 32'h0000_7F01 : 32'h80FF_7F01);
        load(32'h22, 2'b01, 1'b0);
        check("half_high",     Read_data, SUBWORD ? 32'hFFFF_80FF : 32'h80FF_7F01);

        // Misaligned word store, then misaligned half load.
        store(32'h21, 32'h1111_1111, 2'b10);
        check("mis_store_flag", Misalign,  SUBWORD);
        check("mis_store_data", Read_data, SUBWORD ? 32'h0 : 32'h80FF_7F01);
        load(32'h20, 2'b10, 1'b0);
        check("mis_store_kept", Read_data, SUBWORD ? 32'h80FF_7F01 : 32'h1111_1111);
        load(32'h21, 2'b01, 1'b1);
        check("mis_load_valid", Read_valid, !SUBWORD);
        check("mis_load_flag",  Misalign,   SUBWORD);

        // Load/store collision: store wins.
        Mem_read = 1'b1; Memory_write = 1'b1; Address = 32'h30;
        Write_data = 32'h0000_00A5; Mem_size = 2'b00; Mem_unsigned = 1'b1;
        cycle();
        Mem_read = 1'b0; Memory_write = 1'b0;
        check("collide_no_valid", Read_valid, 1'b0);
        load(32'h30, 2'b00, 1'b1);
        check("collide_stored", Read_data, 32'h0000_00A5);
        cycle();
        check("hold_valid", Read_valid, 1'b0);
        check("hold_data",  Read_data,  32'h0000_00A5);

        // Address aliasing above the memory size.
        load(32'h0001_0014, 2'b10, 1'b0);
        check("alias_data", Read_data, 32'hDEAD_BEEF);

        // Load accepted in the cycle that hands memory to the programmer.
        Upg_rst_i = 1'b0; Upg_done_i = 1'b0;
        load(32'h24, 2'b10, 1'b0);
        check("leave_run_valid", Read_valid, 1'b1);
        check("leave_run_data",  Read_data,  32'h1234_5678);
        check("leave_run_prog",  Prog_mode,  1'b1);
        Upg_done_i = 1'b1;
        repeat (2) cycle();
        Upg_rst_i = 1'b1; Upg_done_i = 1'b0;

        // Reset in the response cycle of a load; memory survives.
        load(32'h14, 2'b10, 1'b0);
        Reset_n = 1'b0;
        cycle();
        check("rst_abort_valid", Read_valid, 1'b0);
        check("rst_abort_data",  Read_data,  32'h0);
        Reset_n = 1'b1;
        load(32'h14, 2'b10, 1'b0);
        check("rst_preserve", Read_data, 32'hDEAD_BEEF);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
